aha_clk_switch_ctrl: RTL and testbench

Control-side sequencer for the platform's glitch-free two-source clock switch. It runs in the MASTER_CLK0 domain. It accepts clock-select requests through a valid/ready handshake, drives the switch's SELECT input, and monitors the switch's two per-clock enable flags through synchronizers. It reports completion, or a timeout fault, back to the platform controller. Because it has a hard completion/timeout contract, software never has to guess when the output clock has settled.

---
 rtl/aha_clk_switch_ctrl.sv | 139 +++++++++++++
 tb/tb_aha_clk_switch_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/aha_clk_switch_ctrl.sv
// Control sequencer for the glitch-free two-source clock switch.
// Accepts select requests, drives SELECT, tracks the switch's synchronized
// enable flags and reports DONE, or a sticky ERR when the switch times out.
module aha_clk_switch_ctrl #(
  parameter int unsigned TIMEOUT_W   = 16,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic MASTER_CLK0,
  input  logic master_clk0_reset_n,
  input  logic REQ_VALID,
  input  logic REQ_SEL,
  output logic REQ_READY,
  input  logic ERR_CLR,
  input  logic CLK0_EN_STS,
  input  logic CLK1_EN_STS,
  output logic SELECT,
  output logic CUR_SEL,
  output logic BUSY,
  output logic DONE,
  output logic ERR
);

  localparam logic [TIMEOUT_W-1:0] TMO_MAX  = TIMEOUT_W'(TIMEOUT);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OFF = 2'd1,
    WAIT_ON  = 2'd2,
    FAULT    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   tgt_q, tgt_d;
  logic [TIMEOUT_W-1:0]   timer_q, timer_d;
  logic                   select_d, cur_sel_d, busy_d, done_d, err_d, ready_d;
  logic [SYNC_STAGES-1:0] sync0_q, sync1_q;
  logic                   en0_s, en1_s;
  logic                   exit_c;
  logic                   tmo_c;

  // Enable-flag synchronizers; only the last stage is used by the FSM.
  always_ff @(posedge MASTER_CLK0 or negedge master_clk0_reset_n) begin
    if (!master_clk0_reset_n) begin
      sync0_q <= '0;
      sync1_q <= '0;
    end else begin
      sync0_q <= {sync0_q[SYNC_STAGES-2:0], CLK0_EN_STS};
      sync1_q <= {sync1_q[SYNC_STAGES-2:0], CLK1_EN_STS};
    end
  end

  assign en0_s = sync0_q[SYNC_STAGES-1];
  assign en1_s = sync1_q[SYNC_STAGES-1];

  // State, working registers and registered outputs.
  always_ff @(posedge MASTER_CLK0 or negedge master_clk0_reset_n) begin
    if (!master_clk0_reset_n) begin
      state_q   <= IDLE;
      tgt_q     <= 1'b0;
      timer_q   <= '0;
      SELECT    <= 1'b0;
      CUR_SEL   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      REQ_READY <= 1'b1;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      timer_q   <= timer_d;
      SELECT    <= select_d;
      CUR_SEL   <= cur_sel_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
      ERR       <= err_d;
      REQ_READY <= ready_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    timer_d   = timer_q;
    select_d  = SELECT;
    cur_sel_d = CUR_SEL;
    done_d    = 1'b0;
    exit_c    = 1'b0;
    // >= keeps the fault reachable even if the timer saturated while
    // crossing from WAIT_OFF into WAIT_ON on the last allowed cycle.
    tmo_c     = (timer_q >= TMO_LAST);

    unique case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          if (REQ_SEL == CUR_SEL) begin
            done_d = 1'b1;
          end else begin
            tgt_d    = REQ_SEL;
            select_d = REQ_SEL;
            timer_d  = '0;
            state_d  = WAIT_OFF;
          end
        end
      end
      WAIT_OFF: begin
        if (timer_q != TMO_MAX) timer_d = timer_q + TIMEOUT_W'(1);
        exit_c = tgt_q ? ~en0_s : ~en1_s;
        if (exit_c)     state_d = WAIT_ON;
        else if (tmo_c) state_d = FAULT;
      end
      WAIT_ON: begin
        if (timer_q != TMO_MAX) timer_d = timer_q + TIMEOUT_W'(1);
        exit_c = tgt_q ? en1_s : en0_s;
        if (exit_c) begin
          cur_sel_d = tgt_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else if (tmo_c) begin
          state_d = FAULT;
        end
      end
      FAULT: begin
        if (ERR_CLR) begin
          select_d = CUR_SEL;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == WAIT_OFF) || (state_d == WAIT_ON);
    ready_d = (state_d == IDLE);
    err_d   = (state_d == FAULT);
  end

endmodule

// File: tb/tb_aha_clk_switch_ctrl.sv
// Directed bench for aha_clk_switch_ctrl: vector table plus multi-cycle sequences.
module tb_aha_clk_switch_ctrl;

  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, req_sel, req_ready, err_clr;
  logic en0, en1;
  logic select, cur_sel, busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  aha_clk_switch_ctrl #(.TIMEOUT_W(16), .TIMEOUT(TMO), .SYNC_STAGES(2)) dut (
    .MASTER_CLK0        (clk),
    .master_clk0_reset_n(rst_n),
    .REQ_VALID          (req_valid),
    .REQ_SEL            (req_sel),
    .REQ_READY          (req_ready),
    .ERR_CLR            (err_clr),
    .CLK0_EN_STS        (en0),
    .CLK1_EN_STS        (en1),
    .SELECT             (select),
    .CUR_SEL            (cur_sel),
    .BUSY               (busy),
    .DONE               (done),
    .ERR                (err)
  );

  always #5 clk = ~clk;

  // {SELECT, CUR_SEL, BUSY, DONE, ERR, REQ_READY}
  function automatic logic [5:0] outs();
    return {select, cur_sel, busy, done, err, req_ready};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got sel/cur/busy/done/err/rdy=%b expected %b", name, act, exp);
    end
  endtask

  typedef struct {
    logic       v;
    logic       sel;
    logic       clr;
    logic       e0;
    logic       e1;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[17];
  int   done_seen;

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000001};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000101}; // no-op request
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000001};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b000001}; // ERR_CLR in IDLE
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000001};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000001};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'b101000}; // accept, statuses final
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b101000};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b110101}; // 2-cycle DONE
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'b110101}; // no-op to 1
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b110001};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b110001};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b110001};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b011000}; // switch back
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b011000};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000101};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000001};

    rst_n = 1'b0; req_valid = 1'b0; req_sel = 1'b0; err_clr = 1'b0;
    en0 = 1'b1; en1 = 1'b0;
    tick(); tick();
    check("reset_state", outs(), 6'b000001);
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("post_reset_idle", outs(), 6'b000001);

    // Vector table
    for (int i = 0; i < 17; i++) begin
      req_valid = vecs[i].v; req_sel = vecs[i].sel; err_clr = vecs[i].clr;
      en0 = vecs[i].e0; en1 = vecs[i].e1;
      tick();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end
    req_valid = 1'b0; err_clr = 1'b0;

    // Timeout: request 1 while en0 stays high; ERR exactly TMO edges after accept
    req_valid = 1'b1; req_sel = 1'b1;
    tick();
    req_valid = 1'b0;
    check("tmo_accept", outs(), 6'b101000);
    for (int k = 1; k < int'(TMO); k++) begin
      tick();
      if (k == 8) req_valid = 1'b1;
      if (k == TMO - 1) check("tmo_before", outs(), 6'b101000);
    end
    tick();
    check("tmo_err_rise", outs(), 6'b100010);
    tick();
    check("tmo_err_held_req_blocked", outs(), 6'b100010);
    req_valid = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr_revert", outs(), 6'b000001);

    // Slow switch to 1 with a second request held during BUSY
    req_valid = 1'b1; req_sel = 1'b1;
    tick();
    check("slow_accept", outs(), 6'b101000);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) en0 = 1'b0;
      if (k == 8) en1 = 1'b1;
      if (k == 5 || k == 10) check($sformatf("slow_busy_k%0d", k), outs(), 6'b101000);
    end
    tick();
    check("slow_done", outs(), 6'b110101);
    tick();
    check("held_req_noop_done", outs(), 6'b110101);
    req_valid = 1'b0;
    tick();
    check("slow_done_end", outs(), 6'b110001);

    // Boundary: new enable first seen high exactly when timer == TMO-1
    req_valid = 1'b1; req_sel = 1'b0;
    tick();
    req_valid = 1'b0;
    en1 = 1'b0;
    check("bnd_accept", outs(), 6'b011000);
    for (int k = 1; k <= int'(TMO) - 1; k++) begin
      tick();
      if (k == TMO - 3) en0 = 1'b1;
    end
    check("bnd_still_busy", outs(), 6'b011000);
    tick();
    check("bnd_done_wins", outs(), 6'b000101);

    // Reset mid WAIT_ON
    req_valid = 1'b1; req_sel = 1'b1;
    tick();
    req_valid = 1'b0;
    en0 = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("mid_wait_on_busy", outs(), 6'b101000);
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), 6'b000001);
    en0 = 1'b0; en1 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    req_valid = 1'b1; req_sel = 1'b1;
    tick();
    req_valid = 1'b0;
    en1 = 1'b1;
    check("post_reset_accept", outs(), 6'b101000);
    done_seen = 0;
    for (int k = 0; k < 20 && done_seen == 0; k++) begin
      tick();
      if (done) done_seen = 1;
    end
    n_cmp++;
    if (done_seen == 0) begin
      n_bad++;
      $display("FAIL post_reset_done: no DONE within 20 cycles, expected DONE");
    end else begin
      check("post_reset_done", outs(), 6'b110101);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
